// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int NUM_CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err
);

  if (NUM_CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx_os: NUM_CLKS_PER_BIT must be >= 4");
  end

  localparam int unsigned CW = $clog2(NUM_CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(NUM_CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(NUM_CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic           rx_s;
  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     dout_q, dout_d;
  logic           done_q, done_d;
  logic           fe_q, fe_d;
  logic           bit_end;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rstn),
    .d_i    (rx),
    .q_o    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;
`endif

  assign bit_end = (cnt_q == FULL_M1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_d   = rx_s;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Framing takes priority over parity; a low stop parks in BREAK until the line recovers.
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != ^shift_q) begin
              pe_d = 1'b1;
            end else begin
              dout_d = shift_q;
              done_d = 1'b1;
            end
`else
            dout_d = shift_q;
            done_d = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus random bytes against a frame-level model.
module tb_uart_rx_os;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx_os #(.NUM_CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .dout       (dout),
    .done       (done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  typedef struct packed {
    logic       d;
    logic       fe;
    logic       pe;
    logic [7:0] dout;
  } ev_t;

  ev_t        evq[$];
  ev_t        exq[$];
  int         multi  = 0;
  int         passed = 0;
  int         total  = 0;
  logic [7:0] dout_m = 8'h00;

  // Every output pulse observed after reset becomes one event.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (done || frame_err || parity_err)) begin
      evq.push_back('{d: done, fe: frame_err, pe: parity_err, dout: dout});
      if (int'(done) + int'(frame_err) + int'(parity_err) > 1) multi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame-level reference: one outcome per frame from stop bit, parity and last good byte.
  function automatic ev_t model(input logic [7:0] d, input bit stop, input bit par);
    ev_t e = '0;
    if (!stop) e.fe = 1'b1;
    else if (PAR_EN && (par != ^d)) e.pe = 1'b1;
    else begin
      e.d    = 1'b1;
      dout_m = d;
    end
    e.dout = dout_m;
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(par);
    bits.push_back(stop);
    foreach (bits[i]) begin
      rx = bits[i];
      repeat (N) @(negedge clk);
    end
    if (!stop) repeat (24) @(negedge clk);
    rx = 1'b1;
    exq.push_back(model(d, stop, par));
  endtask

  task automatic drain(input string tag);
    ev_t o, e;
    chk({tag, ".count"}, 32'(evq.size()), 32'(exq.size()));
    while (evq.size() > 0 && exq.size() > 0) begin
      o = evq.pop_front();
      e = exq.pop_front();
      chk({tag, ".event"}, 32'(o), 32'(e));
    end
    evq.delete();
    exq.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         s;
    bit         p;
    int         gap;

    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.dout", 32'(dout), 32'h00);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.frame_err", 32'(frame_err), 32'h0);
    chk("reset.parity_err", 32'(parity_err), 32'h0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    repeat (4) @(negedge clk);
    drain("t1.a5");
    chk("t1.dout", 32'(dout), 32'hA5);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    drain("t2.glitch");

    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (6) @(negedge clk);
    drain("t3.break");
    chk("t3.dout_kept", 32'(dout), 32'hA5);
    send_frame(8'h81, 1'b1, ^8'h81);
    repeat (4) @(negedge clk);
    drain("t3.81");

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    drain("t4.b2b");
    chk("t4.dout", 32'(dout), 32'hFF);

    // Reset halfway through data bit 3 of 0x12.
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h12 >> i) & 8'h01;
      repeat (N) @(negedge clk);
    end
    rx = 1'b0;
    repeat (N / 2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t5.rst_dout", 32'(dout), 32'h00);
    chk("t5.rst_pulses", {29'd0, done, frame_err, parity_err}, 32'h0);
    dout_m = 8'h00;
    evq.delete();
    exq.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    repeat (4) @(negedge clk);
    drain("t5.5a");

    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      p   = ($urandom_range(0, 3) != 0) ? ^d : ~^d;
      gap = $urandom_range(0, 3);
      send_frame(d, s, p);
      repeat (gap) @(negedge clk);
      drain($sformatf("rnd%0d", k));
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    drain("t6.bad_par");
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    drain("t6.good_par");
    chk("t6.dout", 32'(dout), 32'h07);
`endif

    repeat (20) @(negedge clk);
    drain("final.quiet");
    chk("exclusive_pulses", 32'(multi), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
